// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART transmit path.
//   uart_state_t       : transmitter FSM states (IDLE, START, DATA, STOP)
//   DEFAULT_CLK_FREQ   : default system clock frequency in Hz
//   DEFAULT_BAUD_RATE  : default line rate in bit/s
//   DEFAULT_OVERSAMPLE : default number of baud ticks per bit
//   DATA_BITS          : payload bits per frame
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DEFAULT_CLK_FREQ   = 100_000_000;
    localparam int DEFAULT_BAUD_RATE  = 9600;
    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DATA_BITS          = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen -- divides the system clock down to the oversample tick rate.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : restart the count; the first tick then arrives DIV clocks later
//   tick : one-cycle pulse every DIV clocks
// Parameter DIV : clocks per tick (must be at least 2).
module baud_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Decoded from the counter register: after a clear at edge E the counter
    // reaches DIV-1 just after edge E+DIV-1, so the tick is consumed at E+DIV.
    assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   tx_start : send request (pulse or level), accepted only while idle
//   tx_data  : byte to send, captured on acceptance
//   tx_busy  : high while a frame is in progress
//   tx       : serial line, idle high
//   tx_done  : one-cycle pulse at the edge that ends the stop bit
// Parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE set the bit timing:
// one bit = OVERSAMPLE * (CLK_FREQ / (BAUD_RATE * OVERSAMPLE)) clocks.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                 tx_d, busy_d, done_d;
    logic                 accept;
    logic                 tick;
    logic                 bit_end;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // Last oversample tick of the current bit period.
    assign bit_end = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tick_cnt_d = tick_cnt_q;
        tx_d       = tx;
        busy_d     = tx_busy;
        done_d     = 1'b0;
        accept     = 1'b0;

        if (state_q != IDLE && tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    accept     = 1'b1;
                    shift_d    = tx_data;
                    bit_cnt_d  = '0;
                    tick_cnt_d = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        // Next bit is what the shift brings into the LSB.
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Reset outranks a same-cycle tx_start, so a request during reset is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            tx         <= tx_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The parameters SHALL be:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- OVERSAMPLE, 16, baud ticks per bit.
REQ-003 The ports SHALL be:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- tx_start  input  1  request to send tx_data; single-cycle or level.
- tx_data  input  8  byte to transmit; sampled only on acceptance.
- tx_busy  output  1  high while a frame is in progress.
- tx  output  1  serial line; idle high.
- tx_done  output  1  one-cycle pulse at the end of the stop bit.

Function
REQ-004 The tick divisor SHALL be DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), using integer truncation, which gives 651 at the defaults.
- One bit SHALL be OVERSAMPLE*DIV clocks, which is 10416 at the defaults.
REQ-005 The frame format SHALL be 8N1:
- 1 start bit (0).
- 8 data bits, LSB first.
- 1 stop bit (1).
- Total 10 bit periods.
REQ-006 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-007 In IDLE, tx_start=1 at a rising edge SHALL be accepted. At that same edge:
- tx_data is latched into the shift register.
- The state moves to START.
- tx goes to 0 and tx_busy goes to 1.
- The tick divider and the tick and bit counters clear.
REQ-008 START SHALL last exactly one bit period, then move to DATA with bit index 0.
REQ-009 DATA SHALL drive the current LSB of the shift register on tx for one bit period per bit.
- The register shifts right after each bit.
- After bit index 7 the state moves to STOP.
REQ-010 STOP SHALL drive tx=1 for one bit period.
- At the edge ending the stop bit, the state moves to IDLE, tx_done=1 for exactly that one cycle, and tx_busy=0.
REQ-011 tx_start SHALL be ignored while tx_busy=1. tx_data changes during a frame SHALL NOT affect the frame.
REQ-012 tx_start=1 in the first IDLE cycle after tx_done SHALL be accepted. This allows back-to-back frames with zero idle bits.
REQ-013 tx, tx_busy and tx_done SHALL be registered outputs with no combinational path from inputs.
REQ-014 Timing from acceptance edge to tx_done edge SHALL be exactly 10*OVERSAMPLE*DIV clocks, which is 104160 at the defaults.
REQ-015 The bit counter SHALL be 3 bits wide and the tick counter $clog2(OVERSAMPLE) bits wide. Both wrap naturally.
- The divider counter SHALL be $clog2(DIV) bits wide and count 0..DIV-1.

Reset
REQ-016 While rst=1, on each rising edge:
- state=IDLE, tx=1, tx_busy=0, tx_done=0.
- Shift register and all counters = 0.
REQ-017 Reset asserted mid-frame SHALL abandon the frame. tx SHALL return to 1 at the next edge, and no tx_done SHALL be generated.
REQ-018 If rst and tx_start are high in the same cycle, reset SHALL take priority and the request SHALL be dropped.

Structure
REQ-019 Package uart_pkg SHALL hold:
- The FSM state typedef (IDLE/START/DATA/STOP).
- Default CLK_FREQ, BAUD_RATE and OVERSAMPLE constants.
- The DATA_BITS=8 constant.
REQ-020 A sub-module baud_tick_gen SHALL generate the one-cycle oversample tick.
- Ports: clk, rst, clr, tick.
- Parameter: DIV.
- Asserting clr SHALL restart the count so that the first tick arrives DIV clocks later.
REQ-021 uart_tx SHALL instantiate baud_tick_gen once and drive clr on frame acceptance.

Verification
REQ-022 Single byte: tx_start pulse with tx_data=0x31.
- tx sampled at mid-bit SHALL read 0,1,0,0,0,1,1,0,0,1.
- tx_busy SHALL be high for 104160 clocks.
- tx_done SHALL pulse once.
REQ-023 Busy rejection: send 0x31, then tx_start with tx_data=0xFF at clock 50000.
- The line waveform SHALL be identical to REQ-022, with one tx_done only.
REQ-024 Back-to-back: 0x55 accepted, then tx_start held high.
- 0xAA SHALL be accepted the cycle after tx_done.
- The stop bit of 0x55 SHALL be followed immediately by the start bit of 0xAA.
REQ-025 Reset mid-frame: rst=1 for one cycle at clock 30000 of a 0x31 frame.
- tx SHALL be 1 at the next edge.
- tx_busy SHALL be 0 and there SHALL be no tx_done.
- A new 0x31 request SHALL then transmit correctly.
- rst and tx_start asserted in the same cycle SHALL produce no frame.
REQ-026 Loopback: connect tx to the team's UART receiver rx input and send 0x00, 0x31, 0xA5 and 0xFF in sequence.
- rx_data SHALL match each byte in order.
- rx_done SHALL pulse once per byte.
